// File: rtl/ddr2_init_engine_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_pkg: shared types and constants for the DDR2 power-up sequencer.
//   cmd_t   : {csbar,rasbar,casbar,webar} command encodings
//   state_t : sequencer states, in issue order
//   bit positions of the mode-register fields the sequencer modifies
//   wait_load(): counter load value for the pure-wait states
// ----------------------------------------------------------------------------
package ddr2_pkg;

    typedef enum logic [3:0] {
        CMD_MRS   = 4'b0000,
        CMD_REF   = 4'b0001,
        CMD_PREA  = 4'b0010,
        CMD_NOP   = 4'b0111,
        CMD_DESEL = 4'b1111
    } cmd_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CKE_WAIT,
        ST_NOP400,
        ST_PREA1,
        ST_EMRS2,
        ST_EMRS3,
        ST_EMRS1,
        ST_MRS_DLLRST,
        ST_PREA2,
        ST_REF1,
        ST_REF2,
        ST_MRS,
        ST_WAIT_DLL,
        ST_EMRS_OCDDEF,
        ST_EMRS_OCDEXIT,
        ST_DONE
    } state_t;

    localparam int DLL_RST_BIT = 8;
    localparam int OCD_HI      = 9;
    localparam int OCD_LO      = 7;
    localparam int AP_BIT      = 10;

    // A wait state shows its first NOP in the cycle it is entered, so it
    // needs one fewer count than its length to last exactly 'cycles'.
    function automatic int unsigned wait_load(int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/ddr2_init_engine_if.sv
// ----------------------------------------------------------------------------
// ddr2_init_engine_if: start request, completion flag and DDR2 command bus.
//   master : the init engine (drives the command bus and ready, reads init)
//   slave  : the controller side (drives init, reads everything else)
// ----------------------------------------------------------------------------
interface ddr2_init_engine_if;
    import ddr2_pkg::*;

    logic        init;
    logic        ready;
    logic        cke;
    logic        csbar;
    logic        rasbar;
    logic        casbar;
    logic        webar;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        odt;

    modport master (
        input  init,
        output ready, cke, csbar, rasbar, casbar, webar, ba, a, odt
    );

    modport slave (
        output init,
        input  ready, cke, csbar, rasbar, casbar, webar, ba, a, odt
    );

endinterface

// File: rtl/ddr2_init_engine_gap_counter.sv
// ----------------------------------------------------------------------------
// ddr2_gap_counter: loadable down-counter that stops at zero.
//   clk, reset  : clock, synchronous active-high reset (clears the count)
//   load_i      : load load_val_i this cycle (wins over counting)
//   load_val_i  : value to load
//   zero_o      : count is currently zero
// ----------------------------------------------------------------------------
module ddr2_gap_counter #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: combinational blocks assign a default first so that no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr2_init_engine.sv
// ----------------------------------------------------------------------------
// ddr2_init_engine: issues the DDR2 power-up / initialization command stream
// and raises ready once the device is usable.
//   clk   : system clock
//   reset : synchronous active-high reset; restarts from IDLE
//   bus   : master side of ddr2_init_engine_if
//           (init in; ready, cke, csbar/rasbar/casbar/webar, ba, a, odt out)
// Each command state emits its command for one cycle on entry, then NOPs
// until its gap counter has drained, then moves on. All outputs are flops.
// ----------------------------------------------------------------------------
module ddr2_init_engine
    import ddr2_pkg::*;
#(
    parameter int unsigned CNT_W      = 17,
    parameter int unsigned T_CKE_WAIT = 100000,
    parameter int unsigned T_NOP400   = 200,
    parameter int unsigned T_RP       = 8,
    parameter int unsigned T_MRD      = 2,
    parameter int unsigned T_RFC      = 64,
    parameter int unsigned T_DLL      = 200,
    parameter logic [12:0] MR_VAL     = 13'h0443,
    parameter logic [12:0] EMR_VAL    = 13'h0004
) (
    input  logic                 clk,
    input  logic                 reset,
    ddr2_init_engine_if.master   bus
);

    localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

    if (T_CKE_WAIT >= CNT_LIM || T_NOP400 >= CNT_LIM || T_RP >= CNT_LIM ||
        T_MRD >= CNT_LIM || T_RFC >= CNT_LIM || T_DLL >= CNT_LIM) begin : g_bad_param
        $error("ddr2_init_engine: a timing parameter does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LD_CKE  = CNT_W'(wait_load(T_CKE_WAIT));
    localparam logic [CNT_W-1:0] LD_N400 = CNT_W'(wait_load(T_NOP400));
    localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] LD_MRD  = CNT_W'(T_MRD);
    localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC);
    // Loaded in the MRS_DLLRST command cycle; reaching zero one cycle early
    // lets the OCD EMRS land exactly T_DLL cycles after that command.
    localparam logic [CNT_W-1:0] LD_DLL  = CNT_W'(wait_load(T_DLL));

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [1:0]  ba_q, ba_d;
    logic [12:0] a_q, a_d;
    logic        cke_q, cke_d;
    logic        ready_q, ready_d;

    logic             gap_load;
    logic [CNT_W-1:0] gap_val;
    logic             gap_zero;
    logic             dll_load;
    logic             dll_zero;

    ddr2_gap_counter #(.CNT_W(CNT_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (gap_load),
        .load_val_i (gap_val),
        .zero_o     (gap_zero)
    );

    ddr2_gap_counter #(.CNT_W(CNT_W)) u_dll_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (dll_load),
        .load_val_i (LD_DLL),
        .zero_o     (dll_zero)
    );

    // Next-state: advance once the current state's gap has drained.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:         if (bus.init) state_d = ST_CKE_WAIT;
            ST_CKE_WAIT:     if (gap_zero) state_d = ST_NOP400;
            ST_NOP400:       if (gap_zero) state_d = ST_PREA1;
            ST_PREA1:        if (gap_zero) state_d = ST_EMRS2;
            ST_EMRS2:        if (gap_zero) state_d = ST_EMRS3;
            ST_EMRS3:        if (gap_zero) state_d = ST_EMRS1;
            ST_EMRS1:        if (gap_zero) state_d = ST_MRS_DLLRST;
            ST_MRS_DLLRST:   if (gap_zero) state_d = ST_PREA2;
            ST_PREA2:        if (gap_zero) state_d = ST_REF1;
            ST_REF1:         if (gap_zero) state_d = ST_REF2;
            ST_REF2:         if (gap_zero) state_d = ST_MRS;
            // Skip WAIT_DLL entirely when the DLL lock time already elapsed.
            ST_MRS:          if (gap_zero) state_d = dll_zero ? ST_EMRS_OCDDEF : ST_WAIT_DLL;
            ST_WAIT_DLL:     if (dll_zero) state_d = ST_EMRS_OCDDEF;
            ST_EMRS_OCDDEF:  if (gap_zero) state_d = ST_EMRS_OCDEXIT;
            ST_EMRS_OCDEXIT: if (gap_zero) state_d = ST_DONE;
            ST_DONE:         state_d = ST_DONE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Output and counter-load values: a state's command appears only in the
    // cycle it is entered; every other cycle is NOP with ba/a cleared.
    always_comb begin
        if (state_d == ST_IDLE) cmd_d = CMD_DESEL;
        else                    cmd_d = CMD_NOP;
        ba_d     = '0;
        a_d      = '0;
        gap_load = 1'b0;
        gap_val  = '0;
        dll_load = 1'b0;
        if (state_d != state_q) begin
            gap_load = 1'b1;
            unique case (state_d)
                ST_CKE_WAIT: gap_val = LD_CKE;
                ST_NOP400:   gap_val = LD_N400;
                ST_PREA1, ST_PREA2: begin
                    cmd_d          = CMD_PREA;
                    a_d[AP_BIT]    = 1'b1;
                    gap_val        = LD_RP;
                end
                ST_EMRS2: begin
                    cmd_d   = CMD_MRS;
                    ba_d    = 2'd2;
                    gap_val = LD_MRD;
                end
                ST_EMRS3: begin
                    cmd_d   = CMD_MRS;
                    ba_d    = 2'd3;
                    gap_val = LD_MRD;
                end
                ST_EMRS1: begin
                    cmd_d   = CMD_MRS;
                    ba_d    = 2'd1;
                    a_d     = EMR_VAL;
                    gap_val = LD_MRD;
                end
                ST_MRS_DLLRST: begin
                    cmd_d            = CMD_MRS;
                    a_d              = MR_VAL;
                    a_d[DLL_RST_BIT] = 1'b1;
                    gap_val          = LD_MRD;
                    dll_load         = 1'b1;
                end
                ST_REF1, ST_REF2: begin
                    cmd_d   = CMD_REF;
                    gap_val = LD_RFC;
                end
                ST_MRS: begin
                    cmd_d            = CMD_MRS;
                    a_d              = MR_VAL;
                    a_d[DLL_RST_BIT] = 1'b0;
                    gap_val          = LD_MRD;
                end
                ST_EMRS_OCDDEF: begin
                    cmd_d                 = CMD_MRS;
                    ba_d                  = 2'd1;
                    a_d                   = EMR_VAL;
                    a_d[OCD_HI:OCD_LO]    = 3'b111;
                    gap_val               = LD_MRD;
                end
                ST_EMRS_OCDEXIT: begin
                    cmd_d                 = CMD_MRS;
                    ba_d                  = 2'd1;
                    a_d                   = EMR_VAL;
                    a_d[OCD_HI:OCD_LO]    = 3'b000;
                    gap_val               = LD_MRD;
                end
                default: gap_val = '0;
            endcase
        end
        cke_d   = !(state_d inside {ST_IDLE, ST_CKE_WAIT});
        ready_d = (state_d == ST_DONE);
    end

    // NOTE: the reset branch assigns every output flop explicitly because the
    // bus must show a deselected, cke-low device the cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_DESEL;
            ba_q    <= '0;
            a_q     <= '0;
            cke_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            a_q     <= a_d;
            cke_q   <= cke_d;
            ready_q <= ready_d;
        end
    end

    assign bus.csbar  = cmd_q[3];
    assign bus.rasbar = cmd_q[2];
    assign bus.casbar = cmd_q[1];
    assign bus.webar  = cmd_q[0];
    assign bus.ba     = ba_q;
    assign bus.a      = a_q;
    assign bus.cke    = cke_q;
    assign bus.ready  = ready_q;
    // Termination is never enabled during initialization.
    assign bus.odt    = 1'b0;

endmodule

// File: tb/tb_ddr2_init_engine.sv
// ----------------------------------------------------------------------------
// tb_ddr2_init_engine: three engines with shortened timings (T_DLL = 20, 40,
// 1). A schedule model derives every command time from the gap rules and the
// compare process checks all outputs of every engine on every negedge.
// ----------------------------------------------------------------------------
module tb_ddr2_init_engine;

    localparam int T_CKE = 10;
    localparam int T_N4  = 4;
    localparam int T_RP  = 2;
    localparam int T_MRD = 1;
    localparam int T_RFC = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, init_a, rst_bc, init_bc;

    ddr2_init_engine_if bus_a ();
    ddr2_init_engine_if bus_b ();
    ddr2_init_engine_if bus_c ();

    assign bus_a.init = init_a;
    assign bus_b.init = init_bc;
    assign bus_c.init = init_bc;

    ddr2_init_engine #(.CNT_W(17), .T_CKE_WAIT(T_CKE), .T_NOP400(T_N4), .T_RP(T_RP),
                       .T_MRD(T_MRD), .T_RFC(T_RFC), .T_DLL(20),
                       .MR_VAL(13'h0443), .EMR_VAL(13'h0004))
        dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
    ddr2_init_engine #(.CNT_W(17), .T_CKE_WAIT(T_CKE), .T_NOP400(T_N4), .T_RP(T_RP),
                       .T_MRD(T_MRD), .T_RFC(T_RFC), .T_DLL(40),
                       .MR_VAL(13'h0443), .EMR_VAL(13'h0004))
        dut_b (.clk(clk), .reset(rst_bc), .bus(bus_b));
    ddr2_init_engine #(.CNT_W(17), .T_CKE_WAIT(T_CKE), .T_NOP400(T_N4), .T_RP(T_RP),
                       .T_MRD(T_MRD), .T_RFC(T_RFC), .T_DLL(1),
                       .MR_VAL(13'h0443), .EMR_VAL(13'h0004))
        dut_c (.clk(clk), .reset(rst_bc), .bus(bus_c));

    // {ready, cke, odt, csbar, rasbar, casbar, webar, ba[1:0], a[12:0]}
    logic [21:0] act_a, act_b, act_c;
    assign act_a = {bus_a.ready, bus_a.cke, bus_a.odt, bus_a.csbar, bus_a.rasbar,
                    bus_a.casbar, bus_a.webar, bus_a.ba, bus_a.a};
    assign act_b = {bus_b.ready, bus_b.cke, bus_b.odt, bus_b.csbar, bus_b.rasbar,
                    bus_b.casbar, bus_b.webar, bus_b.ba, bus_b.a};
    assign act_c = {bus_c.ready, bus_c.cke, bus_c.odt, bus_c.csbar, bus_c.rasbar,
                    bus_c.casbar, bus_c.webar, bus_c.ba, bus_c.a};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- schedule model ----------------
    // Command index: 0 PREA, 1 EMRS2, 2 EMRS3, 3 EMRS1, 4 MRS+DLLRST, 5 PREA,
    // 6 REF, 7 REF, 8 MRS, 9 EMRS OCD default, 10 EMRS OCD exit, 11 = ready.
    function automatic int gap_after(int i);
        case (i)
            0, 5:    return T_RP;
            6, 7:    return T_RFC;
            default: return T_MRD;
        endcase
    endfunction

    // Cycle (0 = first cycle after leaving IDLE) at which item idx appears.
    function automatic int cmd_time(int idx, int tdll);
        int t = T_CKE + T_N4;
        int t_dll = 0;
        for (int j = 0; j < idx; j++) begin
            if (j == 4) t_dll = t;
            t = t + 1 + gap_after(j);
            if (j == 8 && t < t_dll + tdll) t = t_dll + tdll;
        end
        return t;
    endfunction

    // {cmd, ba, a} of each command.
    function automatic logic [18:0] cmd_word(int i);
        case (i)
            0, 5:    return {4'b0010, 2'd0, 13'h0400};
            1:       return {4'b0000, 2'd2, 13'h0000};
            2:       return {4'b0000, 2'd3, 13'h0000};
            3:       return {4'b0000, 2'd1, 13'h0004};
            4:       return {4'b0000, 2'd0, 13'h0543};
            6, 7:    return {4'b0001, 2'd0, 13'h0000};
            8:       return {4'b0000, 2'd0, 13'h0443};
            9:       return {4'b0000, 2'd1, 13'h0384};
            default: return {4'b0000, 2'd1, 13'h0004};
        endcase
    endfunction

    function automatic logic [21:0] expect_out(int k, int tdll);
        logic cke;
        if (k < 0) return {3'b000, 4'b1111, 15'd0};
        cke = (k >= T_CKE);
        if (k >= cmd_time(11, tdll)) return {3'b110, 4'b0111, 15'd0};
        for (int i = 0; i < 11; i++)
            if (k == cmd_time(i, tdll)) return {1'b0, cke, 1'b0, cmd_word(i)};
        return {1'b0, cke, 1'b0, 4'b0111, 15'd0};
    endfunction

    // k: -2 unknown, -1 idle, else cycles since the engine left IDLE.
    function automatic int step(int k, logic r, logic i);
        if (r) return -1;
        if (k == -2) return -2;
        if (k < 0) return i ? 0 : -1;
        return (k < 100000) ? k + 1 : k;
    endfunction

    int k_a = -2, k_b = -2, k_c = -2;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        k_a <= step(k_a, rst_a, init_a);
        k_b <= step(k_b, rst_bc, init_bc);
        k_c <= step(k_c, rst_bc, init_bc);
    end

    task automatic cmp(input string tag, input logic [21:0] act, input int k, input int tdll);
        check({tag, "_outputs"}, 32'(act), 32'(expect_out(k, tdll)));
        check({tag, "_cmd_while_cke_low"},
              32'(!act[20] && act[18:15] != 4'b0111 && act[18:15] != 4'b1111), 32'd0);
    endtask

    function automatic logic is_cmd(logic [21:0] v);
        return v[18:15] != 4'b0111 && v[18:15] != 4'b1111;
    endfunction

    // ---------------- observation log ----------------
    logic log_en = 1'b0;
    int n_log = 0;
    int log_t[16];
    logic [12:0] log_addr[16];
    int t_start = -1, t_cke = -1, t_rdy = -1;
    int t_dll[2] = '{-1, -1};
    int t_mrs[2] = '{-1, -1};
    int t_ocd[2] = '{-1, -1};
    logic [21:0] act_bc[2];
    assign act_bc[0] = act_b;
    assign act_bc[1] = act_c;

    always @(negedge clk) begin
        if (k_a != -2) cmp("dut_a", act_a, k_a, 20);
        if (k_b != -2) cmp("dut_b", act_b, k_b, 40);
        if (k_c != -2) cmp("dut_c", act_c, k_c, 1);
        if (log_en) begin
            if (!bus_a.csbar && t_start < 0) t_start <= cyc;
            if (bus_a.cke && t_cke < 0)      t_cke   <= cyc;
            if (bus_a.ready && t_rdy < 0)    t_rdy   <= cyc;
            if (is_cmd(act_a) && n_log < 16) begin
                log_t[n_log]    <= cyc;
                log_addr[n_log] <= bus_a.a;
                n_log           <= n_log + 1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (act_bc[i][18:15] == 4'b0000 && act_bc[i][14:13] == 2'd0) begin
                if (act_bc[i][12:0] == 13'h0543) t_dll[i] <= cyc;
                if (act_bc[i][12:0] == 13'h0443) t_mrs[i] <= cyc;
            end
            if (act_bc[i][18:15] == 4'b0000 && act_bc[i][14:13] == 2'd1 &&
                act_bc[i][12:0] == 13'h0384) t_ocd[i] <= cyc;
        end
    end

    int exp_gap[10] = '{2, 1, 1, 1, 1, 2, 5, 5, 2, 1};

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_a = 1'b1; init_a = 1'b0; rst_bc = 1'b1; init_bc = 1'b0;
        log_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("a_reset_ready", 32'(bus_a.ready), 32'd0);
        check("a_reset_csbar", 32'(bus_a.csbar), 32'd1);
        rst_a = 1'b0; init_a = 1'b1;
        rst_bc = 1'b0; init_bc = 1'b1;
        @(posedge clk); #1;
        init_bc = 1'b0;            // B and C see a one-cycle init pulse

        repeat (60) @(posedge clk);
        #1;
        log_en = 1'b0;
        // Toggling init after DONE must change nothing.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            init_a = ~init_a;
        end
        @(negedge clk);
        check("a_ready_held", 32'(bus_a.ready), 32'd1);

        // Literal expectations from the first run of engine A.
        check("a_cmd_count", 32'(n_log), 32'd11);
        for (int i = 0; i < 10; i++)
            check($sformatf("a_gap%0d", i), 32'(log_t[i+1] - log_t[i] - 1), 32'(exp_gap[i]));
        check("a_mrs_dllrst_a", 32'(log_addr[4]),  32'h0543);
        check("a_mrs_a",        32'(log_addr[8]),  32'h0443);
        check("a_ocd_def_a",    32'(log_addr[9]),  32'h0384);
        check("a_ocd_exit_a",   32'(log_addr[10]), 32'h0004);
        check("a_cke_low_len",  32'(t_cke - t_start), 32'd10);
        check("a_prea_after_cke", 32'(log_t[0] - t_cke), 32'd4);
        check("a_ready_after_exit", 32'(t_rdy - log_t[10]), 32'd2);
        check("b_dll_span", 32'(t_ocd[0] - t_dll[0]), 32'd40);
        check("c_dll_span", 32'(t_ocd[1] - t_dll[1]), 32'd19);
        check("c_no_wait",  32'(t_ocd[1] - t_mrs[1]), 32'd2);
        check("model_ocddef_t20", 32'(cmd_time(9, 20)), 32'd43);
        check("model_done_t20",   32'(cmd_time(11, 20)), 32'd47);

        // Restart, then reset during the REF1 gap with init held high.
        init_a = 1'b1; rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        n = 0;
        while (k_a != 30 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_reached_ref1", 32'(k_a == 30), 32'd1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        check("a_midreset_ready", 32'(bus_a.ready), 32'd0);
        check("a_midreset_cke",   32'(bus_a.cke),   32'd0);
        check("a_midreset_csbar", 32'(bus_a.csbar), 32'd1);
        repeat (55) @(posedge clk);
        #1;

        // One-cycle init pulse on A.
        rst_a = 1'b1; init_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0; init_a = 1'b1;
        @(posedge clk); #1;
        init_a = 1'b0;
        repeat (55) @(posedge clk);
        @(negedge clk);
        check("a_pulse_ready", 32'(bus_a.ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
